dot_product_acc: RTL and testbench
==================================

# dot_product_acc

Sequential signed dot-product engine, sitting directly downstream of the signed MxN array multiplier (`mult_mnbit_signed`). It accepts a stream of signed operand pairs over a valid/ready handshake and multiplies each pair with one combinational `mult_mnbit_signed #(W, W)` instance. It accumulates LEN products and presents the finished sum on a valid/ready output port. It replaces the fixed four-product `mult_add` tree wherever operands arrive serially.

## Interface
Parameters:
- `W`, 4: operand width, signed two's complement.
- `LEN`, 4: products per result, ≥ 1.
- `ACC_W`, localparam = 2*W + $clog2(LEN) (minimum 2*W): accumulator and result width. No overflow is possible for any operand values.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept a pair.
- `a`  in  W  signed multiplicand.
- `b`  in  W  signed multiplier.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  ACC_W  signed sum of LEN products.
- `term_cnt`  out  $clog2(LEN+1)  number of pairs accepted in the current result.

## Operation
- Product path: p = a*b via `mult_mnbit_signed #(W, W)`, 2W bits. Sign-extend p to ACC_W before adding.
- State machine has two states: ACCUM and DONE.
  - ACCUM:
    - `in_ready` = 1 and `out_valid` = 0.
    - On accept (`in_valid` && `in_ready`), acc ← acc + sext(p) and term_cnt ← term_cnt + 1.
    - If the accept is the LEN-th (term_cnt == LEN-1 before the accept), go to DONE.
    - `out_data` is registered with acc + sext(p), and term_cnt holds LEN.
    - With no accept, all state holds.
  - DONE:
    - `in_ready` = 0 and `out_valid` = 1.
    - `out_data` is held stable until the handshake.
    - On `out_ready`, go to ACCUM with acc = 0 and term_cnt = 0.
    - `a`, `b` and `in_valid` are ignored while in DONE.
- Arithmetic is full-precision two's complement with no saturation or wrap for legal widths. The most negative operand is legal, e.g. -8 * -8 = +64 for W = 4.
- `out_data` is registered and never combinationally dependent on `a` or `b`.
- Reset (synchronous, any state, including mid-accumulation or DONE):
  - state = ACCUM, acc = 0, term_cnt = 0, out_valid = 0, out_data = 0.
  - Partial sums are discarded.
  - `in_ready` = 0 while `rst` is high (gated) and 1 on the first cycle after release.

## Timing
- Accept rate is one pair per cycle in ACCUM.
- The LEN-th accept at edge k gives `out_valid` = 1 from edge k (visible in cycle k+1).
- With `out_ready` held high, DONE lasts exactly 1 cycle. `in_ready` returns at the following edge.
- Minimum period is LEN+1 cycles per result.
- Backpressure: DONE persists indefinitely while `out_ready` = 0. `out_data` and `out_valid` do not change.
- Gaps in `in_valid` stall accumulation without loss.
- No accept is possible in the same cycle as the output handshake. `in_ready` is low in DONE.
- `out_ready` asserted during ACCUM has no effect.
- Simultaneous `rst` and any handshake: reset wins. Nothing is accepted or emitted.

## Test plan
- W=4, LEN=4, back-to-back pairs (3,2), (-4,5), (7,7), (-8,-8) with `out_ready` = 1 → `out_valid` for one cycle, `out_data` = 99, `term_cnt` = 4, then `in_ready` = 1 and `term_cnt` = 0.
- Extremes, four pairs of (-8,7) → `out_data` = -224. Four pairs of (-8,-8) → +256. Four pairs of (7,-8) → -224. Each result is checked against a behavioural a*b reference sum over 1000 random streams.
- Backpressure: `out_ready` = 0 for 5 cycles after DONE, with `in_valid` = 1 and changing `a`/`b` → `in_ready` = 0 throughout, `out_data` stable at the same value, no extra terms accumulated. The next result starts from 0.
- Bubbles: `in_valid` toggled 1,0,0,1,0,1,1 with pairs (1,1), (2,2), (3,3), (-1,4) → result 10 = 1+4+9-4 after the 4th accept only.
- Reset mid-operation: `rst` pulsed for 1 cycle after 2 accepts, and separately while in DONE → `out_valid` = 0, `term_cnt` = 0, `in_ready` low during reset then high. The next 4 pairs (1,1) give exactly 4.
- LEN=1 build: each pair (5,-3) produces `out_data` = -15 with `out_valid` after one accept. Throughput is one result per 2 cycles.

Source files
------------

// File: rtl/dot_product_acc.sv
// Serial signed dot-product engine: one signed array multiplier feeding an
// accumulator. LEN operand pairs are accepted over a valid/ready input, and
// their summed products leave on a valid/ready output.

// Combinational signed M x N array multiplier built from shifted partial-product rows.
module mult_mnbit_signed #(
   parameter int M = 4,
   parameter int N = 4
) (
   input  logic [M-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [M+N-1:0] p
);
   localparam int PW = M + N;

   logic [PW-1:0] a_ext;

   assign a_ext = PW'($signed(a));

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_row
         logic [PW-1:0] row;
         logic [PW-1:0] part;
         if (gi == N - 1) begin : g_neg
            // The MSB of b has weight -2^(N-1), so its row is subtracted.
            assign row = b[gi] ? (~(a_ext << gi) + PW'(1)) : '0;
         end else begin : g_pos
            assign row = b[gi] ? (a_ext << gi) : '0;
         end
         if (gi == 0) begin : g_first
            assign part = row;
         end else begin : g_chain
            assign part = g_row[gi-1].part + row;
         end
      end
   endgenerate

   assign p = g_row[N-1].part;
endmodule

module dot_product_acc #(
   parameter int W   = 4,
   parameter int LEN = 4,
   localparam int ACC_W = 2 * W + $clog2(LEN),
   localparam int CW    = $clog2(LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic [CW-1:0]    term_cnt
);
   typedef enum logic {
      S_ACCUM = 1'b0,
      S_DONE  = 1'b1
   } state_t;

   localparam logic [CW-1:0] LAST_CNT = CW'(LEN - 1);

   state_t                  state_reg, state_next;
   logic signed [ACC_W-1:0] acc_reg, acc_next;
   logic signed [ACC_W-1:0] out_data_reg, out_data_next;
   logic [CW-1:0]           cnt_reg, cnt_next;
   logic [2*W-1:0]          prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] sum;

   mult_mnbit_signed #(
      .M(W),
      .N(W)
   ) u_mult (
      .a(a),
      .b(b),
      .p(prod)
   );

   // Sign-extend the full-precision product so the sum never overflows.
   assign prod_ext = ACC_W'($signed(prod));
   assign sum      = acc_reg + prod_ext;

   assign out_data = out_data_reg;
   assign term_cnt = cnt_reg;

   // Next-state, accumulate and handshake logic; in_ready is gated off during reset.
   always_comb begin
      state_next    = state_reg;
      acc_next      = acc_reg;
      cnt_next      = cnt_reg;
      out_data_next = out_data_reg;
      in_ready      = 1'b0;
      out_valid     = 1'b0;
      case (state_reg)
         S_ACCUM: begin
            in_ready = ~rst;
            if (in_valid) begin
               acc_next = sum;
               cnt_next = cnt_reg + CW'(1);
               if (cnt_reg == LAST_CNT) begin
                  out_data_next = sum;
                  state_next    = S_DONE;
               end
            end
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               acc_next   = '0;
               cnt_next   = '0;
               state_next = S_ACCUM;
            end
         end
         default: begin
            state_next = S_ACCUM;
         end
      endcase
   end

   // State and datapath registers; reset discards any partial sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_ACCUM;
         acc_reg      <= '0;
         cnt_reg      <= '0;
         out_data_reg <= '0;
      end else begin
         state_reg    <= state_next;
         acc_reg      <= acc_next;
         cnt_reg      <= cnt_next;
         out_data_reg <= out_data_next;
      end
   end
endmodule

// File: tb/tb_dot_product_acc.sv
// Bench for dot_product_acc: directed streams with hand-computed sums, a
// long randomized run checked cycle by cycle against a behavioural model,
// and a LEN=1 instance checked for result value and throughput.
module tb_dot_product_acc;
   localparam int W     = 4;
   localparam int LEN   = 4;
   localparam int ACC_W = 2 * W + $clog2(LEN);
   localparam int CW    = $clog2(LEN + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic                in_valid, in_ready, out_valid, out_ready;
   logic signed [W-1:0] a, b;
   logic [ACC_W-1:0]    out_data;
   logic [CW-1:0]       term_cnt;

   logic                in_valid1, in_ready1, out_valid1, out_ready1;
   logic signed [W-1:0] a1, b1;
   logic [2*W-1:0]      out_data1;
   logic [0:0]          term_cnt1;

   dot_product_acc #(.W(W), .LEN(LEN)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .term_cnt(term_cnt)
   );

   dot_product_acc #(.W(W), .LEN(1)) dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out_data(out_data1), .term_cnt(term_cnt1)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input longint actual, input longint expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Behavioural model: the list of accepted products and whether a finished sum waits.
   int m_terms   = 0;
   int m_sum     = 0;
   int m_result  = 0;
   int m_results = 0;
   bit m_done    = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_terms = 0;
         m_sum   = 0;
         m_done  = 1'b0;
      end else if (m_done) begin
         if (out_ready) begin
            m_terms = 0;
            m_sum   = 0;
            m_done  = 1'b0;
            m_results++;
         end
      end else if (in_valid) begin
         m_sum = m_sum + int'(a) * int'(b);
         m_terms++;
         if (m_terms == LEN) begin
            m_done   = 1'b1;
            m_result = m_sum;
         end
      end
   end

   // Per-cycle comparison of every main-DUT output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", in_ready, (!m_done && !rst));
         check("out_valid", out_valid, m_done);
         check("term_cnt", term_cnt, m_terms);
         if (m_done) check("out_data", $signed(out_data), m_result);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
      bit took;
      bit done_ok = 1'b0;
      in_valid = 1'b1;
      a = x;
      b = y;
      for (int i = 0; i < 50 && !done_ok; i++) begin
         @(negedge clk);
         took = in_ready;
         cyc();
         if (took) done_ok = 1'b1;
      end
      if (!done_ok) check("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic get_result(input string name, input longint expv);
      bit seen = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            check({name, "_data"}, $signed(out_data), expv);
            check({name, "_model"}, m_result, expv);
            check({name, "_cnt"}, term_cnt, LEN);
            $display("result %s = %0d", name, $signed(out_data));
            seen = 1'b1;
         end
         cyc();
      end
      if (!seen) check({name, "_timeout"}, 0, 1);
   endtask

   function automatic logic signed [W-1:0] rand_op();
      case ($urandom_range(0, 3))
         0:       return W'(-8);
         1:       return W'(7);
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
      int pa  [4] = '{1, 2, 3, -1};
      int pb  [4] = '{1, 2, 3, 4};
      int k;
      int base;
      int n_res;

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
      in_valid1 = 1'b0; a1 = '0; b1 = '0; out_ready1 = 1'b0;
      repeat (3) cyc();
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_term_cnt", term_cnt, 0);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      cyc();

      // Basic back-to-back stream.
      send(3, 2); send(-4, 5); send(7, 7); send(-8, -8);
      get_result("basic", 99);
      @(negedge clk);
      check("basic_in_ready_after", in_ready, 1);
      check("basic_cnt_after", term_cnt, 0);
      cyc();

      // Operand extremes.
      repeat (4) send(-8, 7);
      get_result("ext_neg_pos", -224);
      repeat (4) send(-8, -8);
      get_result("ext_neg_neg", 256);
      repeat (4) send(7, -8);
      get_result("ext_pos_neg", -224);

      // Backpressure with busy input side.
      out_ready = 1'b0;
      send(1, 2); send(3, 4); send(5, 6); send(7, -1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         a = W'($urandom);
         b = W'($urandom);
         @(negedge clk);
         check("bp_in_ready", in_ready, 0);
         check("bp_out_valid", out_valid, 1);
         check("bp_out_data", $signed(out_data), 37);
         check("bp_term_cnt", term_cnt, LEN);
         cyc();
      end
      in_valid = 1'b0;
      get_result("bp", 37);
      repeat (4) send(2, 2);
      get_result("bp_next", 16);

      // Bubbles in in_valid.
      k = 0;
      for (int i = 0; i < 7; i++) begin
         in_valid = pat[i][0];
         if (pat[i] == 1) begin
            a = W'(pa[k]);
            b = W'(pb[k]);
            k++;
         end else begin
            a = W'($urandom);
            b = W'($urandom);
         end
         cyc();
      end
      in_valid = 1'b0;
      get_result("bubble", 10);

      // Reset mid-accumulation.
      send(2, 3); send(4, -5);
      rst = 1'b1;
      @(negedge clk);
      check("rmid_in_ready_low", in_ready, 0);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("rmid_term_cnt", term_cnt, 0);
      check("rmid_out_valid", out_valid, 0);
      check("rmid_in_ready_high", in_ready, 1);
      cyc();
      repeat (4) send(1, 1);
      get_result("rst_mid", 4);

      // Reset while a result is waiting.
      out_ready = 1'b0;
      repeat (4) send(3, 3);
      rst = 1'b1;
      @(negedge clk);
      check("rdone_in_ready_low", in_ready, 0);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      check("rdone_out_valid", out_valid, 0);
      check("rdone_term_cnt", term_cnt, 0);
      check("rdone_in_ready_high", in_ready, 1);
      cyc();
      out_ready = 1'b1;
      repeat (4) send(1, 1);
      get_result("rst_done", 4);

      // Randomized streams against the model.
      base = m_results;
      for (int c = 0; c < 30000 && (m_results - base) < 1000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         a         = rand_op();
         b         = rand_op();
         out_ready = $urandom_range(0, 1);
         rst       = ($urandom_range(0, 199) == 0);
         cyc();
      end
      check("random_results", (m_results - base) >= 1000, 1);
      $display("random phase produced %0d results", m_results - base);
      in_valid = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();

      // LEN=1 instance: a result every other cycle.
      n_res = 0;
      in_valid1 = 1'b1; a1 = 5; b1 = -3; out_ready1 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("len1_out_valid", out_valid1, i % 2);
         check("len1_in_ready", in_ready1, 1 - (i % 2));
         check("len1_term_cnt", term_cnt1, i % 2);
         if (out_valid1 === 1'b1) begin
            check("len1_out_data", $signed(out_data1), -15);
            n_res++;
         end
         cyc();
      end
      check("len1_throughput", n_res, 10);
      $display("len1 produced %0d results in 20 cycles", n_res);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
